// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  div_pkg
//  Shared types and constants for the sequential restoring divider.
//  Rev 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int DIV_WIDTH = 6;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = {DIV_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// ============================================================================
//  div_restore_step
//  One combinational restoring-division step: shift in the next dividend bit,
//  trial-subtract the divisor, and keep the difference only if non-negative.
//  Rev 1.0 - initial release
// ============================================================================
module div_restore_step #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder is always below the divisor, so its top bit is
  // zero and dropping it during the shift loses nothing.
  assign shifted = {rem_in[WIDTH-1:0], bit_in};
  assign trial   = shifted - {1'b0, divisor};

  // Restore (keep the shifted value) when the trial subtraction went negative.
  always_comb begin
    q_bit   = ~trial[WIDTH];
    rem_out = trial[WIDTH] ? shifted : trial;
  end

endmodule
`default_nettype wire

// File: rtl/seq_divider_6.sv
`default_nettype none
// ============================================================================
//  seq_divider_6
//  Iterative restoring divider: one quotient bit per clock, start/done
//  handshake, registered quotient/remainder/div_by_zero.
//  Optional build macro SEQ_DIVIDER_SIGNED_EN selects two's-complement
//  operands (truncating division); without it the divider is unsigned only.
//  Rev 1.0 - initial release
// ============================================================================
module seq_divider_6
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  div_state_t       state;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] d_work;
  logic [WIDTH:0]   r_work;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   r_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_work),
    .bit_in  (q_work[WIDTH-1]),
    .divisor (d_work),
    .rem_out (r_next),
    .q_bit   (q_bit)
  );

  // Dividend bits leave Q at the top while quotient bits enter at the bottom.
  assign q_shift = {q_work[WIDTH-2:0], q_bit};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Magnitudes feed the unsigned core; the most negative value maps onto
  // itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    res_q   = neg_q ? -q_shift : q_shift;
    res_r   = neg_r ? -r_next[WIDTH-1:0] : r_next[WIDTH-1:0];
  end

  // Result signs are captured with the operands so the fix-up needs no
  // access to the (possibly changed) input ports at completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start && (state != RUN)) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    res_q   = q_shift;
    res_r   = r_next[WIDTH-1:0];
  end
`endif

  // Control FSM, working registers and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_work      <= '0;
      d_work      <= '0;
      r_work      <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          r_work <= r_next;
          q_work <= q_shift;
          if (count == '0) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= res_q;
            remainder   <= res_r;
            div_by_zero <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a request, giving back-to-back issue.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            q_work <= dvd_mag;
            d_work <= dvs_mag;
            r_work <= '0;
            count  <= CNT_W'(WIDTH - 1);
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
